div_recon_16bit: RTL and testbench

- Sequential inverse of the 16-bit / 8-bit divider: reconstructs the dividend as product = quotient * divisor + remainder.
- Uses a radix-2 shift-add multiplier, one divisor bit per cycle.
- Flags results that could not have come from a valid 16-bit division.
- Sits on the divider's output side as an encode/check path, and feeds self-check and round-trip logic.

---
 rtl/div_recon_16bit.sv | 91 +++++++++
 tb/tb_div_recon_16bit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_recon_16bit.sv
// Reconstructs a dividend from divider outputs: product = quotient * divisor + remainder,
// computed with a radix-2 shift-add loop (one divisor bit per cycle) plus legality flags.
module div_recon_16bit #(
  parameter int QW = 16,
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [QW-1:0]      quotient,
  input  logic [DW-1:0]      divisor,
  input  logic [QW-1:0]      remainder,
  output logic               busy,
  output logic               done,
  output logic [QW+DW-1:0]   product,
  output logic               overflow,
  output logic               rem_err
);

  localparam int PW = QW + DW;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] acc;
  logic [PW-1:0] mcand;
  logic [DW-1:0] mplier;
  logic [CW-1:0] cnt;
  logic          rem_err_r;
  logic [PW-1:0] acc_next;
  logic          cap_rem_err;

  // Handshake: start is a request honoured only while busy is low; the result is
  // valid in the single cycle done is high and is held until the next result.
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  assign acc_next    = acc + (mplier[0] ? mcand : '0);
  assign cap_rem_err = (divisor == '0) |
                       (remainder >= {{(QW-DW){1'b0}}, divisor});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      rem_err_r <= 1'b0;
      product   <= '0;
      overflow  <= 1'b0;
      rem_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc       <= {{DW{1'b0}}, remainder};
            mcand     <= {{DW{1'b0}}, quotient};
            mplier    <= divisor;
            cnt       <= '0;
            rem_err_r <= cap_rem_err;
            state     <= S_CALC;
          end
        end
        S_CALC: begin
          // All DW divisor bits are consumed, even when the divisor is zero, so latency is fixed.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) begin
            product  <= acc_next;
            overflow <= |acc_next[PW-1:QW];
            rem_err  <= rem_err_r;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_recon_16bit.sv
// Randomized scoreboard bench for div_recon_16bit: drivers push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_div_recon_16bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] quotient;
  logic [7:0]  divisor;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic [23:0] product;
  logic        overflow;
  logic        rem_err;

  // Packed expectation: {rem_err, overflow, product}
  logic [25:0] exp_q[$];
  logic [25:0] held;
  int          busy_cyc;
  int          checks;
  int          errors;

  div_recon_16bit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .overflow  (overflow),
    .rem_err   (rem_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the divider identity.
  function automatic logic [25:0] model(input logic [15:0] q, input logic [7:0] b,
                                        input logic [15:0] r);
    int unsigned p;
    logic        ov;
    logic        re;
    p  = int'(q) * int'(b) + int'(r);
    ov = (p > 32'h0000_FFFF);
    re = (b == 8'd0) || (int'(r) >= int'(b));
    return {re, ov, p[23:0]};
  endfunction

  // Driver tasks
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [15:0] q, input logic [7:0] b, input logic [15:0] r,
                       input bit push);
    wait_idle();
    quotient  = q;
    divisor   = b;
    remainder = r;
    start     = 1'b1;
    if (push) exp_q.push_back(model(q, b, r));
    @(posedge clk);
    #1;
    start     = 1'b0;
    quotient  = 16'($urandom);
    divisor   = 8'($urandom);
    remainder = 16'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    if (!done) check("wait_done_timeout", 32'd1, 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [25:0] e;
    if (rst) begin
      held     = '0;
      busy_cyc = 0;
    end else begin
      if (busy) busy_cyc++;
      else busy_cyc = 0;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("product", {8'd0, product}, {8'd0, e[23:0]});
          check("overflow", {31'd0, overflow}, {31'd0, e[24]});
          check("rem_err", {31'd0, rem_err}, {31'd0, e[25]});
          check("latency_busy_cycles", busy_cyc, 32'd9);
          held = e;
        end
      end else begin
        check("hold", {6'd0, rem_err, overflow, product}, {6'd0, held});
      end
    end
  end

  initial begin
    logic [15:0] q;
    logic [7:0]  b;
    logic [15:0] r;
    int          n;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    quotient  = '0;
    divisor   = '0;
    remainder = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_product", {8'd0, product}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_rem_err", {31'd0, rem_err}, 32'd0);
    rst = 1'b0;

    // Directed cases
    issue(16'h0064, 8'h07, 16'h0003, 1'b1);
    issue(16'hFFFF, 8'hFF, 16'h00FE, 1'b1);
    issue(16'h1234, 8'h00, 16'h0005, 1'b1);
    issue(16'h0002, 8'h10, 16'h0010, 1'b1);

    // Start pulses while busy (mid-CALC and during DONE) must be ignored
    issue(16'h0100, 8'h03, 16'h0001, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    quotient = 16'hAAAA; divisor = 8'h55; remainder = 16'h1111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    quotient = 16'h5555; divisor = 8'hAA; remainder = 16'h2222; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("no_accept_in_done", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("still_idle", {31'd0, busy}, 32'd0);

    // Held start: back-to-back acceptance, one result per 10 cycles
    wait_idle();
    quotient = 16'h0C00; divisor = 8'h21; remainder = 16'h0007; start = 1'b1;
    exp_q.push_back(model(16'h0C00, 8'h21, 16'h0007));
    @(posedge clk);
    @(negedge clk);
    quotient = 16'h8001; divisor = 8'hFE; remainder = 16'h0300;
    exp_q.push_back(model(16'h8001, 8'hFE, 16'h0300));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 30);
    check("held_gap_idle", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("held_second_accept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    quotient = '0; divisor = '0; remainder = '0;

    // Reset mid-operation aborts without a done pulse
    issue(16'h4321, 8'h09, 16'h0002, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_product", {8'd0, product}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(16'h0003, 8'h05, 16'h0001, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      q = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 1) == 1 && b != 8'd0) r = 16'($urandom_range(0, int'(b) - 1));
      else r = 16'($urandom);
      issue(q, b, r, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
